// File: rtl/hazard_pkg.sv
// Shared types and encodings for the decode-side hazard tracker.
package hazard_pkg;

  localparam int REG_AW_P = 5;
  localparam int T_W_P    = 2;

  // Tuse value meaning "operand not read by this instruction"
  localparam logic [T_W_P-1:0] TUSE_NONE = 2'd3;

  // Forwarding source encodings
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic                we;
    logic [REG_AW_P-1:0] a3;
    logic [T_W_P-1:0]    tnew;
    logic [REG_AW_P-1:0] a1;
    logic [REG_AW_P-1:0] a2;
  } stage_entry_t;

  // How a stage register transforms tnew on capture
  typedef enum logic [1:0] {
    TNEW_HOLD  = 2'd0,
    TNEW_DEC   = 2'd1,
    TNEW_CLEAR = 2'd2
  } tnew_mode_e;

  function automatic logic [T_W_P-1:0] tnew_step(input tnew_mode_e mode,
                                                  input logic [T_W_P-1:0] t);
    logic [T_W_P-1:0] r;
    case (mode)
      TNEW_DEC:   r = (t == '0) ? '0 : t - 1'b1;
      TNEW_CLEAR: r = '0;
      default:    r = t;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage of hazard bookkeeping: captures the upstream entry,
// ages its tnew, and can be forced to a bubble.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter tnew_mode_e MODE = TNEW_HOLD
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         bubble,
  input  stage_entry_t entry_in,
  output stage_entry_t entry_out
);

  stage_entry_t entry_q;
  stage_entry_t entry_d;

  // Next entry: upstream entry with aged tnew, or an all-zero bubble
  always_comb begin
    entry_d      = entry_in;
    entry_d.tnew = tnew_step(MODE, entry_in.tnew);
    if (bubble) begin
      entry_d = '0;
    end
  end

  // Stage register; reset empties the stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_out = entry_q;

endmodule

// File: rtl/hazard_tracker.sv
// Decode-side hazard resolution: tracks writers through E/M/W and produces
// the D-stage stall, all forwarding selects and a saturating stall counter.
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_P,
  parameter int T_W    = T_W_P,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] a1_d,
  input  logic [REG_AW-1:0] a2_d,
  input  logic [T_W-1:0]    tuse_rs_d,
  input  logic [T_W-1:0]    tuse_rt_d,
  input  logic              we_d,
  input  logic [REG_AW-1:0] a3_d,
  input  logic [T_W-1:0]    tnew_d,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m,
  output logic [CNT_W-1:0]  stall_count
);

  stage_entry_t d_entry;
  stage_entry_t e_entry;
  stage_entry_t m_entry;
  stage_entry_t w_entry;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Stage X writes register r (register 0 never counts as written)
  function automatic logic writes(input stage_entry_t e, input logic [REG_AW_P-1:0] r);
    return e.we && (e.a3 == r) && (r != '0);
  endfunction

  // D-stage source: youngest writer wins, usable only once its result exists
  function automatic logic [1:0] fwd_d_sel(input stage_entry_t e, input stage_entry_t m,
                                           input stage_entry_t w, input logic [REG_AW_P-1:0] r);
    logic [1:0] s;
    s = FWD_RF;
    if (writes(e, r))      s = (e.tnew == '0) ? FWD_E : FWD_RF;
    else if (writes(m, r)) s = (m.tnew == '0) ? FWD_M : FWD_RF;
    else if (writes(w, r)) s = FWD_W;
    return s;
  endfunction

  // E-stage source: M before W, M only once its result exists
  function automatic logic [1:0] fwd_e_sel(input stage_entry_t m, input stage_entry_t w,
                                           input logic [REG_AW_P-1:0] r);
    logic [1:0] s;
    s = FWD_RF;
    if (writes(m, r))      s = (m.tnew == '0) ? FWD_M : FWD_RF;
    else if (writes(w, r)) s = FWD_W;
    return s;
  endfunction

  // Pack the decode bundle; an invalid slot enters the pipe as a bubble
  always_comb begin
    d_entry = '0;
    if (valid_d) begin
      d_entry.we   = we_d;
      d_entry.a3   = a3_d;
      d_entry.tnew = tnew_d;
      d_entry.a1   = a1_d;
      d_entry.a2   = a2_d;
    end
  end

  hazard_stage_reg #(.MODE(TNEW_HOLD)) u_stage_e (
    .clk(clk), .reset_n(reset_n), .bubble(stall), .entry_in(d_entry), .entry_out(e_entry)
  );

  hazard_stage_reg #(.MODE(TNEW_DEC)) u_stage_m (
    .clk(clk), .reset_n(reset_n), .bubble(1'b0), .entry_in(e_entry), .entry_out(m_entry)
  );

  hazard_stage_reg #(.MODE(TNEW_CLEAR)) u_stage_w (
    .clk(clk), .reset_n(reset_n), .bubble(1'b0), .entry_in(m_entry), .entry_out(w_entry)
  );

  // Stall when an operand's producer in E or M cannot deliver in time
  always_comb begin
    logic rs_hit;
    logic rt_hit;
    rs_hit = (tuse_rs_d != TUSE_NONE) &&
             ((writes(e_entry, a1_d) && (e_entry.tnew > tuse_rs_d)) ||
              (writes(m_entry, a1_d) && (m_entry.tnew > tuse_rs_d)));
    rt_hit = (tuse_rt_d != TUSE_NONE) &&
             ((writes(e_entry, a2_d) && (e_entry.tnew > tuse_rt_d)) ||
              (writes(m_entry, a2_d) && (m_entry.tnew > tuse_rt_d)));
    stall  = valid_d && (rs_hit || rt_hit);
  end

  // Forwarding selects, computed regardless of stall
  always_comb begin
    fwd_rs_d = fwd_d_sel(e_entry, m_entry, w_entry, a1_d);
    fwd_rt_d = fwd_d_sel(e_entry, m_entry, w_entry, a2_d);
    fwd_rs_e = fwd_e_sel(m_entry, w_entry, e_entry.a1);
    fwd_rt_e = fwd_e_sel(m_entry, w_entry, e_entry.a2);
    fwd_rt_m = writes(w_entry, m_entry.a2);
  end

  // Saturating stall-cycle counter next value
  always_comb begin
    count_d = count_q;
    if (stall && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign stall_count = count_q;

  // Fields the hazard logic never needs downstream
  logic unused_bits;
  assign unused_bits = ^{m_entry.a1, w_entry.a1, w_entry.a2, w_entry.tnew};

endmodule
